// File: rtl/pipe_pkg.sv
// Shared pipeline types: forwarding select codes and the per-stage tracker entry.
package pipe_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_WBRET = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              load;
  } stage_info_t;

  // A stage produces rs when it holds a real register-writing instruction targeting rs.
  function automatic logic stage_hit(stage_info_t s, logic [REG_AW-1:0] rs, logic zero_hw);
    return s.valid & s.wr & (s.rd == rs) & ~(zero_hw & (rs == '0));
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority compare of one source register against the EX/MEM/WB tracker entries.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int unsigned ZERO_REG_HARDWIRED = 1
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              uses,
  input  stage_info_t       ex,
  input  stage_info_t       mem,
  input  stage_info_t       wb,
  output fwd_sel_t          sel_c,
  output logic              ex_load_hit_c
);

  localparam logic ZERO_HW = (ZERO_REG_HARDWIRED != 0);

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  assign hit_ex  = stage_hit(ex,  rs, ZERO_HW);
  assign hit_mem = stage_hit(mem, rs, ZERO_HW);
  assign hit_wb  = stage_hit(wb,  rs, ZERO_HW);

  // Youngest producer wins.
  always_comb begin
    sel_c = FWD_RF;
    if (uses) begin
      if (hit_ex) begin
        sel_c = FWD_EXMEM;
      end else if (hit_mem) begin
        sel_c = FWD_MEMWB;
      end else if (hit_wb) begin
        sel_c = FWD_WBRET;
      end
    end
  end

  // A load still in EX cannot be forwarded yet; the consumer must wait a cycle.
  assign ex_load_hit_c = uses & hit_ex & ex.load & ~mem.load & ~wb.load
                       | uses & hit_ex & ex.load & (mem.load | wb.load);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding control with load-use stall and bubble insertion.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW             = pipe_pkg::REG_AW,
  parameter int unsigned ZERO_REG_HARDWIRED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              ex_bubble
);

  import pipe_pkg::*;

  localparam int unsigned RD_W = pipe_pkg::REG_AW;

  stage_info_t ex_q;
  stage_info_t mem_q;
  stage_info_t wb_q;
  stage_info_t ex_d;

  fwd_sel_t a_sel_c;
  fwd_sel_t b_sel_c;
  fwd_sel_t a_d;
  fwd_sel_t b_d;
  logic     a_load_hit_c;
  logic     b_load_hit_c;
  logic     advance_c;
  logic     bubble_d;

  fwd_match #(.ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_match_a (
    .rs            (RD_W'(id_rs1)),
    .uses          (id_uses_rs1),
    .ex            (ex_q),
    .mem           (mem_q),
    .wb            (wb_q),
    .sel_c         (a_sel_c),
    .ex_load_hit_c (a_load_hit_c)
  );

  fwd_match #(.ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_match_b (
    .rs            (RD_W'(id_rs2)),
    .uses          (id_uses_rs2),
    .ex            (ex_q),
    .mem           (mem_q),
    .wb            (wb_q),
    .sel_c         (b_sel_c),
    .ex_load_hit_c (b_load_hit_c)
  );

  // Flush has priority over the load-use stall.
  assign stall     = id_valid & ~flush & (a_load_hit_c | b_load_hit_c);
  assign advance_c = id_valid & ~stall & ~flush;

  // Next EX entry and selects; anything that does not advance becomes a bubble.
  always_comb begin
    ex_d     = '0;
    a_d      = FWD_RF;
    b_d      = FWD_RF;
    bubble_d = 1'b1;
    if (advance_c) begin
      ex_d.valid = 1'b1;
      ex_d.rd    = RD_W'(id_rd);
      ex_d.wr    = id_reg_write;
      ex_d.load  = id_is_load;
      a_d        = a_sel_c;
      b_d        = b_sel_c;
      bubble_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
      ex_bubble <= 1'b1;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      fwd_a_sel <= a_d;
      fwd_b_sel <= b_d;
      ex_bubble <= bubble_d;
    end
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control source for the EX-stage operand select muxes (4:1, 2-bit select, 32-bit data).
- Tracks the destination registers of in-flight instructions in EX, MEM and WB.
- Produces registered 2-bit forwarding selects for operands A and B, valid for the whole EX cycle.
- Raises a same-cycle stall on a load-use hazard and inserts a bubble into EX.

Parameters:
- REG_AW, 5, register address width.
- ZERO_REG_HARDWIRED, 1, when 1 register 0 never matches for forwarding or stall.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_AW  source register A.
- id_rs2  in  REG_AW  source register B.
- id_uses_rs1  in  1  instruction reads rs1.
- id_uses_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_AW  destination register.
- id_reg_write  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load; result is available at end of MEM only.
- flush  in  1  branch redirect; kills the ID instruction entering EX.
- stall  out  1  combinational; holds PC and IF/ID this cycle.
- fwd_a_sel  out  2  registered select for the operand-A mux in EX.
- fwd_b_sel  out  2  registered select for the operand-B mux in EX.
- ex_bubble  out  1  registered; EX holds no valid instruction.

Behaviour:
- Select codes: 00 = ID/EX register-file value; 01 = EX/MEM ALU result; 10 = MEM/WB write-back data; 11 = retired WB value (one cycle past MEM/WB).
- Tracker: three entries (ex, mem, wb), each holding {valid, rd, wr, load}.
- Every cycle, mem<=ex and wb<=mem.
- ex<=ID fields when id_valid & !stall & !flush; otherwise ex.valid<=0 (bubble).
- Match(stage, rs): stage.valid & stage.wr & stage.rd==rs & !(ZERO_REG_HARDWIRED & rs==0).
- Per operand (only if id_uses_rsN): priority ex -> 01, else mem -> 10, else wb -> 11, else 00. The youngest producer wins.
- stall = id_valid & !flush & ex.valid & ex.load & (Match(ex,rs1)&uses_rs1 | Match(ex,rs2)&uses_rs2).
- Stall lasts exactly 1 cycle: next cycle the load sits in mem and the select resolves to 10.
- On the clock edge fwd_*_sel <= computed select when an instruction advances. On stall, flush or !id_valid the selects load 00 and ex_bubble loads 1.
- Latency: select is visible in the cycle the instruction occupies EX (1 cycle after its ID cycle).
- Simultaneous flush and stall condition: flush wins; stall=0, bubble inserted.
- Unused operand: select 00 regardless of matches.
- Instruction with id_reg_write=0 is tracked but never matches.
- Reset: all entry valids 0, fwd_a_sel=fwd_b_sel=00, ex_bubble=1, stall=0 (no valid entries).
- Reset mid-operation clears the tracker. Matches against pre-reset instructions must not occur after reset.

Decomposition:
- Shared package pipe_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_WBRET=2'b11.
  - stage_info_t struct {valid, rd, wr, load}.
  - REG_AW default constant.
- One natural sub-module, fwd_match: combinational priority compare of one source against three stage_info_t entries, returning fwd_sel_t. Instantiated twice.
- Tracker registers and stall logic stay in the top.

Test Plan:
- reset high 2 cycles -> fwd_a_sel=fwd_b_sel=00, ex_bubble=1, stall=0; then add r3,r1,r2 followed by sub r4,r3,r5 -> sub in EX has fwd_a_sel=01, fwd_b_sel=00.
- add r3 ; nop ; or r6,r3,r3 -> or in EX has fwd_a_sel=fwd_b_sel=10. With two nops between -> 11. With three nops -> 00.
- lw r7 ; add r8,r7,r1 -> stall=1 for exactly one cycle, ex_bubble=1 that cycle. Next cycle add in EX with fwd_a_sel=10.
- add r0,r1,r2 ; add r9,r0,r0 (ZERO_REG_HARDWIRED=1) -> selects 00. add r5 ; add r5 ; add r10,r5,r5 -> selects 01 (youngest wins).
- lw r7 ; add r8,r7,r1 with flush asserted in the hazard cycle -> stall=0, bubble inserted, no select other than 00 recorded.
- lw r7 issued, reset asserted the following cycle -> tracker empty. A post-reset add r8,r7,r1 gets stall=0 and select 00.
